spi_burst_ctrl: RTL and testbench
=================================

# spi_burst_ctrl

Multi-requester burst controller in front of the SPI master. It grants the single SPI master to one of NREQ requesters by round-robin and applies that requester's SPI mode (CPOL/CPHA). It then streams the requester's bytes through the master's start/done handshake one byte at a time, and closes the transaction with end_signal so SS deasserts. A watchdog aborts a byte the master never completes.

## Interface
- NREQ, 2, number of requesters (2..8)
- LEN_W, 4, width of per-requester byte count
- SETUP_CYC, 4, cycles the mode is held stable before the first byte (covers the master's mode FSM passing through IDLE)
- GAP_CYC, 2, idle cycles with SS high between bursts
- TIMEOUT, 1024, max cycles waiting for spi_done per byte
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- req  in  NREQ  level request per requester
- req_len  in  NREQ*LEN_W  packed byte count per requester; 0 = empty burst
- req_mode  in  NREQ*2  packed {CPHA,CPOL} per requester
- tx_data  in  NREQ*8  packed byte per requester
- tx_valid  in  NREQ  byte valid per requester
- tx_ready  out  NREQ  byte accepted; only the granted bit can be 1
- gnt  out  NREQ  one-hot grant, held for the whole burst
- cmpl  out  NREQ  1-cycle burst-complete pulse to the granted requester
- err  out  1  1-cycle pulse on watchdog abort
- busy  out  1  high in every state except IDLE
- spi_start  out  1  to master start
- spi_tx_data  out  8  to master tx_data
- spi_end  out  1  to master end_signal
- spi_cpol, spi_cpha  out  1 each  to master CPOL/CPHA
- spi_done  in  1  master done pulse
- spi_ready  in  1  master ready

## Operation
- States: IDLE, CONFIG, FETCH, LAUNCH, WAIT_DONE, END, GAP.
- IDLE: if any req, a round-robin pick is made. The search starts at last_gnt+1, wrapping; last_gnt resets to NREQ-1, so requester 0 has first priority. The winner's req_len and req_mode are captured into remaining and the mode regs. gnt is set and the FSM moves to CONFIG. If the captured length is 0, go directly to END: cmpl pulses, there is no SPI activity, and spi_end still pulses (harmless while SS is high).
- CONFIG: spi_cpol/spi_cpha driven from the captured mode. After SETUP_CYC cycles, go to FETCH.
- FETCH: tx_ready[g]=1. When tx_valid[g] is high in the same cycle, the byte is registered into spi_tx_data and the FSM goes to LAUNCH.
- LAUNCH: wait for spi_ready=1, then assert spi_start for exactly 1 cycle and go to WAIT_DONE. The watchdog is cleared.
- WAIT_DONE: on spi_done, remaining decrements. If the result is 0, go to END; otherwise go to FETCH. If the watchdog reaches TIMEOUT, err pulses and the FSM goes to END with the remaining bytes discarded.
- END: spi_end=1 and cmpl[g]=1 for 1 cycle. last_gnt is updated to g. Go to GAP. gnt clears on leaving END.
- GAP: GAP_CYC cycles, then IDLE.
- spi_tx_data and the mode outputs hold their values between bursts. tx_ready is 0 outside FETCH.
- Dropping req mid-burst does not abort the burst. The granted requester must supply all req_len bytes.
- Width rules: remaining is LEN_W bits. The watchdog counter is $clog2(TIMEOUT+1) bits and saturates.

## Timing
- Reset values: all outputs 0 (gnt, tx_ready, cmpl, err, busy, spi_start, spi_end, spi_tx_data, spi_cpol, spi_cpha). Internally, state=IDLE and last_gnt=NREQ-1.
- Reset mid-burst returns the FSM to IDLE immediately and does not issue spi_end. The master shares the same reset.
- req seen in IDLE at cycle 0: gnt and busy go high at cycle 1, and the mode outputs are valid at cycle 1.
- First possible spi_start is at cycle 1+SETUP_CYC+1, assuming tx_valid is already high and spi_ready is high.
- Byte-to-byte: spi_done at cycle t gives FETCH at t+1. If tx_valid is high, the next spi_start is at t+2.
- If spi_done and watchdog expiry coincide, spi_done wins: no err, normal decrement.
- Requests are arbitrated only in IDLE. New requests during a burst wait.
- Minimum idle between bursts is GAP_CYC+1 cycles.

## Structure
- spi_mode_pkg gains spi_burst_state_e (the FSM enum) and a localparam for the {CPHA,CPOL} field width.
- One sub-module, rr_arbiter #(NREQ): inputs req and last_gnt, output a one-hot pick, purely combinational. The controller registers the pick into gnt.
- The top contains the FSM, the remaining/setup/gap/watchdog counters, and the output registers.

## Test plan
- Single burst: req[0]=1, len=3, mode=2'b01, bytes A5,3C,FF. Expect: gnt=01; spi_cpol=1, spi_cpha=0; three spi_start pulses carrying A5,3C,FF each after the prior spi_done; one spi_end; cmpl[0] pulses once; err=0.
- Round-robin: req=11 held high, each len=1. Expect grants in the order 0,1,0,1. Each gnt is separated by END plus GAP_CYC cycles.
- Empty burst: req[1]=1, len=0. Expect cmpl[1] pulse within 3 cycles of the grant, and spi_start never asserted.
- Backpressure: tx_valid[0] low for 10 cycles in FETCH. Expect tx_ready[0]=1 throughout, no spi_start, and resumption on the first valid.
- Watchdog: TIMEOUT=16, spi_done never returned. Expect err pulse 16 cycles after spi_start, then spi_end and cmpl. Also drive spi_done on cycle 16 exactly: expect no err.
- Reset mid-burst after byte 1: all outputs 0 the next cycle and busy=0. After reset releases, req[0] is granted first.

Source files
------------

// File: rtl/spi_mode_pkg.sv
// Shared SPI mode types and the burst controller's state encoding.
package spi_mode_pkg;

  localparam int MODE_W = 2;

  // Packed in the order requesters present it: {CPHA,CPOL}.
  typedef struct packed {
    logic cpha;
    logic cpol;
  } spi_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONFIG,
    ST_FETCH,
    ST_LAUNCH,
    ST_WAIT_DONE,
    ST_END,
    ST_GAP
  } spi_burst_state_e;

endpackage

// File: rtl/spi_burst_ctrl_if.sv
// Requester-side and SPI-master-side signals of the burst controller.
interface spi_burst_ctrl_if #(
  parameter int NREQ  = 2,
  parameter int LEN_W = 4
);

  logic [NREQ-1:0]                      req;
  logic [NREQ*LEN_W-1:0]                req_len;
  logic [NREQ*spi_mode_pkg::MODE_W-1:0] req_mode;
  logic [NREQ*8-1:0]                    tx_data;
  logic [NREQ-1:0]                      tx_valid;
  logic [NREQ-1:0]                      tx_ready;
  logic [NREQ-1:0]                      gnt;
  logic [NREQ-1:0]                      cmpl;
  logic                                 err;
  logic                                 busy;
  logic                                 spi_start;
  logic [7:0]                           spi_tx_data;
  logic                                 spi_end;
  logic                                 spi_cpol;
  logic                                 spi_cpha;
  logic                                 spi_done;
  logic                                 spi_ready;

  modport master (
    input  req, req_len, req_mode, tx_data, tx_valid, spi_done, spi_ready,
    output tx_ready, gnt, cmpl, err, busy, spi_start, spi_tx_data, spi_end,
           spi_cpol, spi_cpha
  );

  modport slave (
    output req, req_len, req_mode, tx_data, tx_valid, spi_done, spi_ready,
    input  tx_ready, gnt, cmpl, err, busy, spi_start, spi_tx_data, spi_end,
           spi_cpol, spi_cpha
  );

endinterface

// File: rtl/spi_burst_ctrl_rr_arbiter.sv
// Combinational round-robin pick: the first requester after i_last_gnt, wrapping.
module rr_arbiter #(
  parameter int  NREQ  = 2,
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [IDX_W-1:0] i_last_gnt,
  output logic [NREQ-1:0]  o_pick
);

  int w_idx;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    o_pick = '0;
    w_idx  = 0;
    // Scan farthest-to-nearest so the requester right after last_gnt overwrites the rest.
    for (int k = NREQ; k >= 1; k--) begin
      w_idx = (int'(i_last_gnt) + k) % NREQ;
      if (i_req[w_idx]) begin
        o_pick        = '0;
        o_pick[w_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_burst_ctrl.sv
// Burst controller: grants the shared SPI master round-robin, applies the winner's
// mode, streams its bytes through start/done and closes the transaction with spi_end.
module spi_burst_ctrl
  import spi_mode_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int LEN_W     = 4,
  parameter int SETUP_CYC = 4,
  parameter int GAP_CYC   = 2,
  parameter int TIMEOUT   = 1024
) (
  input logic              clock,
  input logic              reset,
  spi_burst_ctrl_if.master bus
);

  localparam int IDX_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WD_W    = $clog2(TIMEOUT + 1);
  localparam int SETUP_W = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;
  localparam int GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  spi_burst_state_e   r_state;
  logic [NREQ-1:0]    r_gnt;
  logic [IDX_W-1:0]   r_gidx;
  logic [IDX_W-1:0]   r_last_gnt;
  logic [LEN_W-1:0]   r_rem;
  logic [SETUP_W-1:0] r_setup;
  logic [GAP_W-1:0]   r_gap;
  logic [WD_W-1:0]    r_wd;
  logic [7:0]         r_tx_data;
  spi_mode_t          r_mode;

  logic [NREQ-1:0]  w_pick;
  logic [IDX_W-1:0] w_pick_idx;
  logic [LEN_W-1:0] w_pick_len;
  spi_mode_t        w_pick_mode;
  logic             w_abort;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .i_req      (bus.req),
    .i_last_gnt (r_last_gnt),
    .o_pick     (w_pick)
  );

  always_comb begin
    w_pick_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_pick[k]) w_pick_idx = IDX_W'(k);
    end
    w_pick_len  = bus.req_len[w_pick_idx*LEN_W +: LEN_W];
    w_pick_mode = spi_mode_t'(bus.req_mode[w_pick_idx*MODE_W +: MODE_W]);
  end

  // A done arriving in the expiry cycle still counts as a completed byte.
  assign w_abort = (r_state == ST_WAIT_DONE) && !bus.spi_done && (r_wd >= WD_W'(TIMEOUT));

  assign bus.gnt         = r_gnt;
  assign bus.tx_ready    = (r_state == ST_FETCH) ? r_gnt : '0;
  assign bus.cmpl        = (r_state == ST_END) ? r_gnt : '0;
  assign bus.spi_end     = (r_state == ST_END);
  assign bus.busy        = (r_state != ST_IDLE);
  assign bus.spi_start   = (r_state == ST_LAUNCH) && bus.spi_ready;
  assign bus.err         = w_abort;
  assign bus.spi_tx_data = r_tx_data;
  assign bus.spi_cpol    = r_mode.cpol;
  assign bus.spi_cpha    = r_mode.cpha;

  // NOTE: all state uses non-blocking assignments; reset is asynchronous and clears every register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_gnt      <= '0;
      r_gidx     <= '0;
      r_last_gnt <= IDX_W'(NREQ - 1);
      r_rem      <= '0;
      r_setup    <= '0;
      r_gap      <= '0;
      r_wd       <= '0;
      r_tx_data  <= '0;
      r_mode     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|bus.req) begin
            r_gnt   <= w_pick;
            r_gidx  <= w_pick_idx;
            r_rem   <= w_pick_len;
            r_mode  <= w_pick_mode;
            r_setup <= '0;
            r_state <= (w_pick_len == '0) ? ST_END : ST_CONFIG;
          end
        end
        ST_CONFIG: begin
          if (r_setup == SETUP_W'(SETUP_CYC - 1)) r_state <= ST_FETCH;
          else                                    r_setup <= r_setup + 1'b1;
        end
        ST_FETCH: begin
          if (bus.tx_valid[r_gidx]) begin
            r_tx_data <= bus.tx_data[r_gidx*8 +: 8];
            r_state   <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          // The start cycle itself is the first cycle the watchdog counts.
          if (bus.spi_ready) begin
            r_wd    <= WD_W'(1);
            r_state <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (bus.spi_done) begin
            r_rem   <= r_rem - 1'b1;
            r_state <= (r_rem == LEN_W'(1)) ? ST_END : ST_FETCH;
          end else if (w_abort) begin
            r_state <= ST_END;
          end else if (r_wd < WD_W'(TIMEOUT)) begin
            r_wd <= r_wd + 1'b1;
          end
        end
        ST_END: begin
          r_last_gnt <= r_gidx;
          r_gnt      <= '0;
          r_gap      <= '0;
          r_state    <= ST_GAP;
        end
        ST_GAP: begin
          if (r_gap == GAP_W'(GAP_CYC - 1)) r_state <= ST_IDLE;
          else                              r_gap   <= r_gap + 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Scoreboard bench for spi_burst_ctrl: stimulus queues expectations, a negedge monitor consumes them.
module tb_spi_burst_ctrl;
  import spi_mode_pkg::*;

  localparam int NREQ      = 2;
  localparam int LEN_W     = 4;
  localparam int SETUP_CYC = 4;
  localparam int GAP_CYC   = 2;
  localparam int TIMEOUT   = 16;
  localparam int DONE_LAT  = 3;
  localparam int RESP_NORMAL = 0, RESP_NONE = 1, RESP_EDGE = 2;

  typedef struct {
    logic [7:0] data;
    logic       cpol;
    logic       cpha;
  } byte_exp_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  spi_burst_ctrl_if #(.NREQ(NREQ), .LEN_W(LEN_W)) bus ();

  spi_burst_ctrl #(
    .NREQ(NREQ), .LEN_W(LEN_W), .SETUP_CYC(SETUP_CYC), .GAP_CYC(GAP_CYC), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  byte_exp_t       exp_byte_q[$];
  logic [NREQ-1:0] exp_cmpl_q[$];
  logic [NREQ-1:0] exp_gnt_q[$];
  int              exp_err_q[$];
  int              start_cyc_q[$];
  int              low_gap_q[$];
  logic [7:0]      feed_q[NREQ][$];
  logic [NREQ-1:0] hold = '0;

  int gnt_rises = 0, spi_end_cnt = 0, done_cnt = 0;
  int last_start = 0, gnt_rise_cyc = 0, gnt_fall_cyc = -1;
  int last_cmpl_cyc = 0, last_err_cyc = 0, last_end_cyc = 0;
  int resp_mode = RESP_NORMAL;

  task automatic check(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got an unexpected pulse, expected none", name);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    forever begin
      @(posedge clock);
      cyc++;
    end
  end

  // Monitor: pops expectations whenever the DUT presents an event.
  initial begin
    logic [NREQ-1:0] prev_gnt;
    byte_exp_t       e;
    prev_gnt = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_gnt = '0;
      end else begin
        if (bus.spi_start) begin
          last_start = cyc;
          start_cyc_q.push_back(cyc);
          if (exp_byte_q.size() == 0) unexpected("spi_start");
          else begin
            e = exp_byte_q.pop_front();
            check("spi_tx_data", bus.spi_tx_data, e.data);
            check("spi_cpol", bus.spi_cpol, e.cpol);
            check("spi_cpha", bus.spi_cpha, e.cpha);
          end
        end
        if (bus.cmpl != '0) begin
          last_cmpl_cyc = cyc;
          if (exp_cmpl_q.size() == 0) unexpected("cmpl");
          else check("cmpl", bus.cmpl, exp_cmpl_q.pop_front());
        end
        if (bus.err) begin
          last_err_cyc = cyc;
          if (exp_err_q.size() == 0) unexpected("err");
          else check("err_latency", cyc - last_start, exp_err_q.pop_front());
        end
        if (bus.spi_end) begin
          spi_end_cnt++;
          last_end_cyc = cyc;
        end
        if (bus.gnt != '0 && prev_gnt == '0) begin
          gnt_rises++;
          gnt_rise_cyc = cyc;
          if (gnt_fall_cyc >= 0) low_gap_q.push_back(cyc - gnt_fall_cyc);
          if (exp_gnt_q.size() == 0) unexpected("gnt");
          else check("gnt", bus.gnt, exp_gnt_q.pop_front());
        end
        if (bus.gnt == '0 && prev_gnt != '0) gnt_fall_cyc = cyc;
        if ((bus.tx_ready & ~bus.gnt) != '0) unexpected("tx_ready_outside_gnt");
        prev_gnt = bus.gnt;
      end
    end
  end

  // SPI master model: answers each start with a done pulse after a chosen delay.
  initial begin
    bus.spi_done  = 1'b0;
    bus.spi_ready = 1'b1;
    forever begin
      @(negedge clock);
      if (bus.spi_start && !reset && resp_mode != RESP_NONE) begin
        repeat ((resp_mode == RESP_EDGE) ? TIMEOUT : DONE_LAT) @(posedge clock);
        #1 bus.spi_done = 1'b1;
        @(posedge clock);
        #1 bus.spi_done = 1'b0;
        done_cnt++;
      end
    end
  end

  // Requester byte feeders: present the head of feed_q[i] until it is accepted.
  initial begin
    logic [NREQ-1:0] acc;
    bus.tx_valid = '0;
    bus.tx_data  = '0;
    forever begin
      @(negedge clock);
      acc = bus.tx_ready & bus.tx_valid;
      @(posedge clock);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i] && feed_q[i].size() > 0) void'(feed_q[i].pop_front());
        if (!hold[i] && feed_q[i].size() > 0) begin
          bus.tx_valid[i]       = 1'b1;
          bus.tx_data[i*8 +: 8] = feed_q[i][0];
        end else begin
          bus.tx_valid[i] = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "simulation time limit");
  end

  task automatic set_req(input int i, input int len, input logic [1:0] mode);
    bus.req_len[i*LEN_W +: LEN_W] = LEN_W'(len);
    bus.req_mode[i*2 +: 2]        = mode;
  endtask

  task automatic push_byte(input logic [7:0] d, input logic cpol, input logic cpha);
    byte_exp_t e;
    e.data = d;
    e.cpol = cpol;
    e.cpha = cpha;
    exp_byte_q.push_back(e);
  endtask

  task automatic wait_rises(input int target, input string name);
    int b = 0;
    while (gnt_rises < target && b < 500) begin tick(1); b++; end
    check(name, int'(gnt_rises >= target), 1);
  endtask

  task automatic wait_ends(input int target, input string name);
    int b = 0;
    while (spi_end_cnt < target && b < 500) begin tick(1); b++; end
    check(name, int'(spi_end_cnt >= target), 1);
    tick(GAP_CYC + 2);
  endtask

  task automatic drain_check(input string name);
    check({name, "_pending_bytes"}, exp_byte_q.size(), 0);
    check({name, "_pending_cmpl"}, exp_cmpl_q.size(), 0);
    check({name, "_pending_gnt"}, exp_gnt_q.size(), 0);
    check({name, "_pending_err"}, exp_err_q.size(), 0);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_gnt"}, bus.gnt, 0);
    check({name, "_tx_ready"}, bus.tx_ready, 0);
    check({name, "_cmpl"}, bus.cmpl, 0);
    check({name, "_err"}, bus.err, 0);
    check({name, "_busy"}, bus.busy, 0);
    check({name, "_spi_start"}, bus.spi_start, 0);
    check({name, "_spi_end"}, bus.spi_end, 0);
    check({name, "_spi_tx_data"}, bus.spi_tx_data, 0);
    check({name, "_spi_cpol"}, bus.spi_cpol, 0);
    check({name, "_spi_cpha"}, bus.spi_cpha, 0);
  endtask

  initial begin
    int c0, e0, r0, d0, x;
    reset        = 1'b1;
    bus.req      = '0;
    bus.req_len  = '0;
    bus.req_mode = '0;
    tick(3);
    check_outputs_zero("reset");
    reset = 1'b0;
    tick(2);

    // Round-robin from reset: requester 0 first, then alternating.
    feed_q[0] = '{8'h10, 8'h11};
    feed_q[1] = '{8'h20, 8'h21};
    set_req(0, 1, 2'b10);
    set_req(1, 1, 2'b11);
    push_byte(8'h10, 1'b0, 1'b1); push_byte(8'h20, 1'b1, 1'b1);
    push_byte(8'h11, 1'b0, 1'b1); push_byte(8'h21, 1'b1, 1'b1);
    exp_gnt_q  = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_cmpl_q = '{2'b01, 2'b10, 2'b01, 2'b10};
    low_gap_q.delete();
    tick(2);
    e0 = spi_end_cnt;
    r0 = gnt_rises;
    bus.req = 2'b11;
    wait_rises(r0 + 4, "rr_four_grants");
    bus.req = '0;
    wait_ends(e0 + 4, "rr_four_ends");
    check("rr_gap_count", low_gap_q.size(), 3);
    foreach (low_gap_q[i]) check("rr_gnt_low_cycles", low_gap_q[i], GAP_CYC + 1);
    drain_check("rr");

    // Single burst: three bytes, mode {CPHA,CPOL}=01; req dropped after grant.
    feed_q[0] = '{8'hA5, 8'h3C, 8'hFF};
    set_req(0, 3, 2'b01);
    push_byte(8'hA5, 1'b1, 1'b0); push_byte(8'h3C, 1'b1, 1'b0); push_byte(8'hFF, 1'b1, 1'b0);
    exp_gnt_q.push_back(2'b01);
    exp_cmpl_q.push_back(2'b01);
    start_cyc_q.delete();
    tick(2);
    e0 = spi_end_cnt;
    bus.req = 2'b01;
    c0 = cyc;
    tick(1);
    check("single_gnt_cycle1", bus.gnt, 2'b01);
    check("single_busy_cycle1", bus.busy, 1);
    check("single_cpol_cycle1", bus.spi_cpol, 1);
    check("single_cpha_cycle1", bus.spi_cpha, 0);
    bus.req = '0;
    wait_ends(e0 + 1, "single_end");
    check("single_end_count", spi_end_cnt - e0, 1);
    check("single_start_count", start_cyc_q.size(), 3);
    if (start_cyc_q.size() == 3) begin
      check("single_first_start", start_cyc_q[0] - c0, SETUP_CYC + 2);
      check("single_byte2_spacing", start_cyc_q[1] - start_cyc_q[0], DONE_LAT + 2);
      check("single_byte3_spacing", start_cyc_q[2] - start_cyc_q[1], DONE_LAT + 2);
    end
    drain_check("single");

    // Empty burst on requester 1: cmpl and spi_end, no start.
    set_req(1, 0, 2'b00);
    exp_gnt_q.push_back(2'b10);
    exp_cmpl_q.push_back(2'b10);
    e0 = spi_end_cnt;
    r0 = gnt_rises;
    bus.req = 2'b10;
    wait_rises(r0 + 1, "empty_grant");
    bus.req = '0;
    wait_ends(e0 + 1, "empty_end");
    check("empty_cmpl_within_3", int'(last_cmpl_cyc - gnt_rise_cyc <= 3), 1);
    check("empty_end_count", spi_end_cnt - e0, 1);
    drain_check("empty");

    // Backpressure: tx_valid withheld for 10 FETCH cycles.
    hold[0]   = 1'b1;
    feed_q[0] = '{8'h5A};
    set_req(0, 1, 2'b01);
    push_byte(8'h5A, 1'b1, 1'b0);
    exp_gnt_q.push_back(2'b01);
    exp_cmpl_q.push_back(2'b01);
    e0 = spi_end_cnt;
    bus.req = 2'b01;
    x = 0;
    while (bus.tx_ready[0] !== 1'b1 && x < 40) begin tick(1); x++; end
    bus.req = '0;
    check("bp_reach_fetch", bus.tx_ready[0], 1);
    for (int i = 0; i < 10; i++) begin
      check("bp_tx_ready", bus.tx_ready[0], 1);
      check("bp_no_start", bus.spi_start, 0);
      tick(1);
    end
    start_cyc_q.delete();
    hold[0] = 1'b0;
    c0 = cyc;
    wait_ends(e0 + 1, "bp_end");
    check("bp_start_count", start_cyc_q.size(), 1);
    if (start_cyc_q.size() == 1) check("bp_resume_prompt", int'(start_cyc_q[0] - c0 <= 3), 1);
    drain_check("bp");

    // Watchdog: master never answers, err 16 cycles after start, then END.
    resp_mode = RESP_NONE;
    feed_q[0] = '{8'h77, 8'h88};
    set_req(0, 2, 2'b00);
    push_byte(8'h77, 1'b0, 1'b0);
    exp_gnt_q.push_back(2'b01);
    exp_cmpl_q.push_back(2'b01);
    exp_err_q.push_back(TIMEOUT);
    e0 = spi_end_cnt;
    bus.req = 2'b01;
    tick(1);
    bus.req = '0;
    wait_ends(e0 + 1, "wd_end");
    check("wd_end_after_err", last_end_cyc - last_err_cyc, 1);
    check("wd_end_count", spi_end_cnt - e0, 1);
    feed_q[0].delete();
    tick(2);
    drain_check("wd");

    // Watchdog edge: done in the expiry cycle wins, no err.
    resp_mode = RESP_EDGE;
    feed_q[0] = '{8'h99};
    set_req(0, 1, 2'b11);
    push_byte(8'h99, 1'b1, 1'b1);
    exp_gnt_q.push_back(2'b01);
    exp_cmpl_q.push_back(2'b01);
    tick(2);
    e0 = spi_end_cnt;
    bus.req = 2'b01;
    tick(1);
    bus.req = '0;
    wait_ends(e0 + 1, "wd_edge_end");
    check("wd_edge_end_timing", last_end_cyc - last_start, TIMEOUT + 1);
    drain_check("wd_edge");

    // Reset mid-burst after the first byte completes.
    resp_mode = RESP_NORMAL;
    feed_q[0] = '{8'hC1, 8'hC2, 8'hC3};
    set_req(0, 3, 2'b01);
    push_byte(8'hC1, 1'b1, 1'b0);
    exp_gnt_q.push_back(2'b01);
    tick(2);
    e0 = spi_end_cnt;
    d0 = done_cnt;
    bus.req = 2'b01;
    tick(1);
    bus.req = '0;
    x = 0;
    while (done_cnt == d0 && x < 100) begin tick(1); x++; end
    check("rst_first_done", int'(done_cnt > d0), 1);
    reset = 1'b1;
    feed_q[0].delete();
    @(negedge clock);
    check_outputs_zero("midrst");
    tick(2);
    reset = 1'b0;
    check("midrst_no_spi_end", spi_end_cnt - e0, 0);
    drain_check("midrst");

    // After reset requester 0 wins first again.
    feed_q[0] = '{8'hE0};
    feed_q[1] = '{8'hE1};
    set_req(0, 1, 2'b01);
    set_req(1, 1, 2'b11);
    push_byte(8'hE0, 1'b1, 1'b0);
    exp_gnt_q.push_back(2'b01);
    exp_cmpl_q.push_back(2'b01);
    tick(2);
    e0 = spi_end_cnt;
    r0 = gnt_rises;
    bus.req = 2'b11;
    wait_rises(r0 + 1, "postrst_grant");
    bus.req = '0;
    wait_ends(e0 + 1, "postrst_end");
    feed_q[1].delete();
    drain_check("postrst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
